// File: rtl/sc_backg_scroll_ctrl.sv
// Background scroll controller: drives clear/load/shift/data of the 4-bit background-type register.
// Latency: clear 1 cycle after start, load 1 cycle after pattern handshake, shifts every STEP_PERIOD cycles.
// Backpressure: waits in WAIT_PAT with pattern_req_Out=1 for as long as pattern_valid_In stays low.
//
// Ports:
//   SC_RegBACKGTYPE_CLOCK_50 / SC_RegBACKGTYPE_RESET_InHigh : clock, async active-high reset
//   start_InLow, stop_InLow, direction_In                   : game-control commands
//   pattern_valid_In, pattern_InBUS, pattern_req_Out        : upstream pattern request/valid handshake
//   clear_OutLow, load_OutLow, shiftselection_Out,
//   data_OutBUS                                             : background-type register controls
//   busy_Out                                                : high whenever not IDLE
// Optional feature: define SC_BACKGSCROLL_BOUNCE_EN to make the direction flip on every pattern
// after the first one following start.
module sc_backg_scroll_ctrl #(
    parameter int BACKG_DATAWIDTH   = 4,
    parameter int STEP_PERIOD       = 16,
    parameter int STEPS_PER_PATTERN = 4
) (
    input  logic                       SC_RegBACKGTYPE_CLOCK_50,
    input  logic                       SC_RegBACKGTYPE_RESET_InHigh,
    input  logic                       start_InLow,
    input  logic                       stop_InLow,
    input  logic                       direction_In,
    input  logic                       pattern_valid_In,
    input  logic [BACKG_DATAWIDTH-1:0] pattern_InBUS,
    output logic                       pattern_req_Out,
    output logic                       clear_OutLow,
    output logic                       load_OutLow,
    output logic [1:0]                 shiftselection_Out,
    output logic [BACKG_DATAWIDTH-1:0] data_OutBUS,
    output logic                       busy_Out
);

    localparam int TICK_W = $clog2((STEP_PERIOD < 2) ? 2 : STEP_PERIOD);
    localparam int STEP_W = $clog2((STEPS_PER_PATTERN < 2) ? 2 : STEPS_PER_PATTERN);

    // COUNT lasts STEP_PERIOD-1 cycles and SHIFT one more, giving STEP_PERIOD per step.
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_PERIOD - 2);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS_PER_PATTERN - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_WAIT_PAT = 3'd2,
        S_LOAD     = 3'd3,
        S_COUNT    = 3'd4,
        S_SHIFT    = 3'd5
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [BACKG_DATAWIDTH-1:0]   r_hold;
    logic                         r_dir_q;
    logic [TICK_W-1:0]            r_tick;
    logic [STEP_W-1:0]            r_step;
    logic                         w_handshake;

    // A stop on the handshake edge wins: the pattern is not consumed.
    assign w_handshake = (r_state == S_WAIT_PAT) && pattern_valid_In && stop_InLow;

    always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
        if (SC_RegBACKGTYPE_RESET_InHigh) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

`ifdef SC_BACKGSCROLL_BOUNCE_EN
    logic r_first_hs;

    always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
        if (SC_RegBACKGTYPE_RESET_InHigh) begin
            r_dir_q    <= 1'b0;
            r_first_hs <= 1'b1;
        end else if (r_state == S_CLEAR) begin
            r_first_hs <= 1'b1;
        end else if (w_handshake) begin
            r_first_hs <= 1'b0;
            r_dir_q    <= r_first_hs ? direction_In : ~r_dir_q;
        end
    end
`else
    always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
        if (SC_RegBACKGTYPE_RESET_InHigh) begin
            r_dir_q <= 1'b0;
        end else if (w_handshake) begin
            r_dir_q <= direction_In;
        end
    end
`endif

    always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
        if (SC_RegBACKGTYPE_RESET_InHigh) begin
            r_hold <= '0;
            r_tick <= '0;
            r_step <= '0;
        end else begin
            if (w_handshake) begin
                r_hold <= pattern_InBUS;
            end
            case (r_state)
                S_LOAD: begin
                    r_tick <= '0;
                    r_step <= '0;
                end
                S_COUNT: begin
                    if (r_tick == TICK_LAST) begin
                        r_tick <= '0;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_step != STEP_LAST) begin
                        r_step <= r_step + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next             = r_state;
        clear_OutLow       = 1'b1;
        load_OutLow        = 1'b1;
        shiftselection_Out = 2'b00;
        pattern_req_Out    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!start_InLow) begin
                    w_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                clear_OutLow = 1'b0;
                w_next       = S_WAIT_PAT;
            end
            S_WAIT_PAT: begin
                pattern_req_Out = 1'b1;
                if (pattern_valid_In) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                load_OutLow = 1'b0;
                w_next      = S_COUNT;
            end
            S_COUNT: begin
                if (r_tick == TICK_LAST) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shiftselection_Out = r_dir_q ? 2'b10 : 2'b01;
                w_next             = (r_step == STEP_LAST) ? S_WAIT_PAT : S_COUNT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Stop overrides every transition, including a simultaneous start in IDLE.
        if (!stop_InLow) begin
            w_next = S_IDLE;
        end
    end

    assign data_OutBUS = r_hold;
    assign busy_Out    = (r_state != S_IDLE);

endmodule

// File: tb/tb_sc_backg_scroll_ctrl.sv
// Directed bench for sc_backg_scroll_ctrl with a behavioural model of the background-type register.
// Latency: expectations are cycle-exact relative to the start and handshake edges.
// Backpressure: exercises a long pattern_valid_In stall in WAIT_PAT.
module tb_sc_backg_scroll_ctrl;

    logic       clk;
    logic       rst;
    logic       start_n;
    logic       stop_n;
    logic       dir;
    logic       pat_vld;
    logic [3:0] pat_dat;
    logic       req;
    logic       clr_n;
    logic       ld_n;
    logic [1:0] shsel;
    logic [3:0] data;
    logic       busy;

    int n_cmp;
    int n_err;

    logic [3:0] model_reg;

    sc_backg_scroll_ctrl #(
        .BACKG_DATAWIDTH  (4),
        .STEP_PERIOD      (16),
        .STEPS_PER_PATTERN(4)
    ) dut (
        .SC_RegBACKGTYPE_CLOCK_50    (clk),
        .SC_RegBACKGTYPE_RESET_InHigh(rst),
        .start_InLow                 (start_n),
        .stop_InLow                  (stop_n),
        .direction_In                (dir),
        .pattern_valid_In            (pat_vld),
        .pattern_InBUS               (pat_dat),
        .pattern_req_Out             (req),
        .clear_OutLow                (clr_n),
        .load_OutLow                 (ld_n),
        .shiftselection_Out          (shsel),
        .data_OutBUS                 (data),
        .busy_Out                    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural background-type register driven by the DUT strobes.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reg <= 4'b0000;
        end else if (!clr_n) begin
            model_reg <= 4'b0000;
        end else if (!ld_n) begin
            model_reg <= data;
        end else if (shsel == 2'b01) begin
            model_reg <= {model_reg[2:0], model_reg[3]};
        end else if (shsel == 2'b10) begin
            model_reg <= {model_reg[0], model_reg[3:1]};
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_clr"},   {31'd0, clr_n}, 32'd1);
        check_val({tag, "_ld"},    {31'd0, ld_n},  32'd1);
        check_val({tag, "_shift"}, {30'd0, shsel}, 32'd0);
        check_val({tag, "_data"},  {28'd0, data},  32'd0);
        check_val({tag, "_req"},   {31'd0, req},   32'd0);
        check_val({tag, "_busy"},  {31'd0, busy},  32'd0);
    endtask

    // Entered at a negedge while in WAIT_PAT; leaves at a negedge back in WAIT_PAT.
    // exp_seq holds the register value after strobe k in nibble k-1.
    task automatic do_pattern(input string tag, input logic [3:0] pat, input logic d,
                              input logic [1:0] code, input logic [15:0] exp_seq);
        logic [3:0] prev;
        pat_dat = pat;
        dir     = d;
        pat_vld = 1'b1;
        cyc(1);
        check_val({tag, "_load"},     {31'd0, ld_n},  32'd0);
        check_val({tag, "_loaddata"}, {28'd0, data},  {28'd0, pat});
        pat_vld = 1'b0;
        pat_dat = 4'b0000;
        prev    = pat;
        for (int k = 0; k < 4; k++) begin
            cyc(15);
            check_val({tag, "_noshift"}, {30'd0, shsel},     32'd0);
            check_val({tag, "_reg"},     {28'd0, model_reg}, {28'd0, prev});
            cyc(1);
            check_val({tag, "_strobe"},  {30'd0, shsel},     {30'd0, code});
            prev = exp_seq[4*k +: 4];
        end
        cyc(1);
        check_val({tag, "_regfinal"}, {28'd0, model_reg}, {28'd0, prev});
        check_val({tag, "_req"},      {31'd0, req},       32'd1);
        check_val({tag, "_hold"},     {28'd0, data},      {28'd0, pat});
    endtask

    // Never more than one of clear/load/shift in a cycle.
    always @(negedge clk) begin
        if (!rst) begin
            check_val("excl", {31'd0, ($countones({~clr_n, ~ld_n, (shsel != 2'b00)}) <= 1)}, 32'd1);
        end
    end

    initial begin
        logic saw_bad;
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        start_n = 1'b1;
        stop_n  = 1'b1;
        dir     = 1'b0;
        pat_vld = 1'b0;
        pat_dat = 4'b0000;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        check_reset_outputs("rst");

        // Start pulse: CLEAR for one cycle, then request.
        start_n = 1'b0;
        cyc(1);
        check_val("clear_low",  {31'd0, clr_n}, 32'd0);
        check_val("clear_busy", {31'd0, busy},  32'd1);
        check_val("clear_req",  {31'd0, req},   32'd0);
        start_n = 1'b1;
        cyc(1);
        check_val("clear_end",  {31'd0, clr_n}, 32'd1);
        check_val("wait_req",   {31'd0, req},   32'd1);
        check_val("wait_busy",  {31'd0, busy},  32'd1);

        do_pattern("left",  4'b0001, 1'b0, 2'b01, {4'b0001, 4'b1000, 4'b0100, 4'b0010});
        do_pattern("right", 4'b1000, 1'b1, 2'b10, {4'b1000, 4'b0001, 4'b0010, 4'b0100});

        // Stall in WAIT_PAT.
        saw_bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (shsel != 2'b00 || req != 1'b1 || ld_n != 1'b1) saw_bad = 1'b1;
        end
        check_val("stall_quiet", {31'd0, saw_bad}, 32'd0);
        check_val("stall_req",   {31'd0, req},     32'd1);
        // Third handshake uses left shifts in both builds (bounce flips right back to left).
        do_pattern("stall", 4'b1010, 1'b0, 2'b01, {4'b1010, 4'b0101, 4'b1010, 4'b0101});

        // Stop in the middle of COUNT.
        pat_dat = 4'b0011;
        pat_vld = 1'b1;
        cyc(1);
        pat_vld = 1'b0;
        cyc(5);
        stop_n = 1'b0;
        cyc(1);
        check_val("stop_busy",  {31'd0, busy},  32'd0);
        check_val("stop_shift", {30'd0, shsel}, 32'd0);
        check_val("stop_hold",  {28'd0, data},  32'h3);
        start_n = 1'b0;
        saw_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (shsel != 2'b00 || busy != 1'b0) saw_bad = 1'b1;
        end
        check_val("stop_start_idle", {31'd0, saw_bad}, 32'd0);
        stop_n  = 1'b1;
        start_n = 1'b1;
        cyc(2);
        check_val("idle_busy", {31'd0, busy}, 32'd0);

        // Restart and hit reset while a shift strobe is active.
        start_n = 1'b0;
        cyc(1);
        start_n = 1'b1;
        cyc(1);
        dir     = 1'b0;
        pat_dat = 4'b0101;
        pat_vld = 1'b1;
        cyc(1);
        pat_vld = 1'b0;
        cyc(16);
        check_val("pre_rst_shift", {30'd0, shsel}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        check_val("midrst_model", {28'd0, model_reg}, 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        check_reset_outputs("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
